// File: rtl/booth_mult_r4.sv
// Radix-4 Booth multiplier with start/done handshake, runtime signed/unsigned
// operands and a registered product held until the next completion.
module booth_mult_r4 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned ITER = WIDTH / 2 + 1;
  localparam int unsigned QW   = WIDTH + 2;
  localparam int unsigned AW   = WIDTH + 4;
  localparam int unsigned CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state, state_nxt;
  logic          load_c, step_c, last_c;
  logic [AW-1:0] acc, acc_nxt, addend, sum, mr_wide;
  logic [QW-1:0] qr, qr_nxt, mr, m_ext, q_ext;
  logic          q_m1, q_m1_nxt;
  logic [CW-1:0] cnt;

  // Operand extension chosen by mode at capture time
  assign m_ext = signed_mode ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
  assign q_ext = signed_mode ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
  assign last_c = (cnt == CW'(1));

  // Next-state and datapath enables
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    step_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = CALC;
        end
      end
      CALC: begin
        step_c = 1'b1;
        if (last_c) state_nxt = DONE;
      end
      DONE: begin
        if (start) begin
          load_c    = 1'b1;
          state_nxt = CALC;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One Booth digit: add/subtract 0, M or 2M, then arithmetic shift by two
  always_comb begin
    mr_wide = {{2{mr[QW-1]}}, mr};
    addend  = '0;
    case ({qr[1:0], q_m1})
      3'b001, 3'b010: addend = mr_wide;
      3'b011:         addend = mr_wide << 1;
      3'b100:         addend = ~(mr_wide << 1) + AW'(1);
      3'b101, 3'b110: addend = ~mr_wide + AW'(1);
      default:        addend = '0;
    endcase
    sum      = acc + addend;
    acc_nxt  = {{2{sum[AW-1]}}, sum[AW-1:2]};
    qr_nxt   = {sum[1:0], qr[QW-1:2]};
    q_m1_nxt = qr[1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == CALC);
      done  <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      qr      <= '0;
      q_m1    <= 1'b0;
      mr      <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (load_c) begin
      acc  <= '0;
      qr   <= q_ext;
      q_m1 <= 1'b0;
      mr   <= m_ext;
      cnt  <= CW'(ITER);
    end else if (step_c) begin
      acc  <= acc_nxt;
      qr   <= qr_nxt;
      q_m1 <= q_m1_nxt;
      cnt  <= cnt - CW'(1);
      // Low 2*WIDTH bits of {ACC,QR} after the final shift
      if (last_c) product <= {acc_nxt[WIDTH-3:0], qr_nxt};
    end
  end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Directed bench for booth_mult_r4 at WIDTH=8 and WIDTH=16: vector table,
// handshake corner cases, asynchronous reset and a 16-bit random sweep.
module tb_booth_mult_r4;

  logic        clk = 1'b0;
  logic        reset;
  logic        s8, sm8, busy8, done8;
  logic [7:0]  m8, q8;
  logic [15:0] p8;
  logic        s16, sm16, busy16, done16;
  logic [15:0] m16, q16;
  logic [31:0] p16;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sm;
    logic [7:0]  m;
    logic [7:0]  q;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl [12];

  booth_mult_r4 #(.WIDTH(8)) d8 (
    .clk(clk), .reset(reset), .start(s8), .signed_mode(sm8),
    .multiplicand(m8), .multiplier(q8), .busy(busy8), .done(done8), .product(p8)
  );

  booth_mult_r4 #(.WIDTH(16)) d16 (
    .clk(clk), .reset(reset), .start(s16), .signed_mode(sm16),
    .multiplicand(m16), .multiplier(q16), .busy(busy16), .done(done16), .product(p16)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic op8(input logic sm, input logic [7:0] m, input logic [7:0] q,
                     input logic [15:0] exp, input string name);
    int n;
    @(negedge clk);
    s8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
    @(negedge clk);
    s8 = 1'b0; sm8 = ~sm; m8 = 8'($urandom); q8 = 8'($urandom);
    chk({name, "_busy"}, 64'(busy8), 64'd1);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'd5);
    chk({name, "_prod"}, 64'(p8), 64'(exp));
    @(negedge clk);
    chk({name, "_pulse"}, 64'(done8), 64'd0);
  endtask

  task automatic op16(input logic sm, input logic [15:0] m, input logic [15:0] q,
                      input logic [31:0] exp, input string name);
    int n;
    @(negedge clk);
    s16 = 1'b1; sm16 = sm; m16 = m; q16 = q;
    @(negedge clk);
    s16 = 1'b0; m16 = 16'($urandom); q16 = 16'($urandom);
    n = 0;
    while (done16 !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_lat"}, 64'(n), 64'd9);
    chk({name, "_prod"}, 64'(p16), 64'(exp));
  endtask

  initial begin
    int n;
    longint a, b;
    logic [31:0] e;
    logic        rs;
    logic [15:0] rm, rq;

    tbl[0]  = '{1'b1, 8'h80, 8'h80, 16'h4000};
    tbl[1]  = '{1'b0, 8'hFF, 8'hFF, 16'hFE01};
    tbl[2]  = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
    tbl[3]  = '{1'b1, 8'hFD, 8'h07, 16'hFFEB};
    tbl[4]  = '{1'b0, 8'hFD, 8'h07, 16'h06EB};
    tbl[5]  = '{1'b0, 8'h02, 8'h03, 16'h0006};
    tbl[6]  = '{1'b1, 8'h05, 8'h05, 16'h0019};
    tbl[7]  = '{1'b1, 8'h7F, 8'h80, 16'hC080};
    tbl[8]  = '{1'b0, 8'h80, 8'h80, 16'h4000};
    tbl[9]  = '{1'b1, 8'h7F, 8'h7F, 16'h3F01};
    tbl[10] = '{1'b0, 8'h00, 8'hAB, 16'h0000};
    tbl[11] = '{1'b1, 8'hFF, 8'h01, 16'hFFFF};

    reset = 1'b0;
    s8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
    s16 = 1'b0; sm16 = 1'b0; m16 = '0; q16 = '0;
    #12;
    chk("rst_busy8", 64'(busy8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_prod8", 64'(p8), 64'd0);
    chk("rst_busy16", 64'(busy16), 64'd0);
    chk("rst_done16", 64'(done16), 64'd0);
    chk("rst_prod16", 64'(p16), 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 12; i++)
      op8(tbl[i].sm, tbl[i].m, tbl[i].q, tbl[i].exp, $sformatf("vec%0d", i));

    // start pulsed at E2 while busy must be ignored
    @(negedge clk);
    s8 = 1'b1; sm8 = 1'b1; m8 = 8'd3; q8 = 8'd4;
    @(negedge clk);
    s8 = 1'b0;
    @(negedge clk);
    s8 = 1'b1; m8 = 8'h55; q8 = 8'h11;
    @(negedge clk);
    s8 = 1'b0;
    n = 2;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_lat", 64'(n), 64'd5);
    chk("ign_prod", 64'(p8), 64'h000C);
    @(negedge clk);
    chk("ign_done", 64'(done8), 64'd0);
    chk("ign_busy", 64'(busy8), 64'd0);

    // start held through DONE launches the next operation immediately
    @(negedge clk);
    s8 = 1'b1; sm8 = 1'b0; m8 = 8'd6; q8 = 8'd7;
    @(negedge clk);
    s8 = 1'b0;
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat1", 64'(n), 64'd5);
    chk("b2b_prod1", 64'(p8), 64'h002A);
    s8 = 1'b1; sm8 = 1'b1; m8 = 8'd2; q8 = 8'd3;
    @(negedge clk);
    s8 = 1'b0;
    chk("b2b_busy", 64'(busy8), 64'd1);
    chk("b2b_hold", 64'(p8), 64'h002A);
    n = 0;
    while (done8 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_lat2", 64'(n), 64'd5);
    chk("b2b_prod2", 64'(p8), 64'h0006);

    // asynchronous reset in the middle of CALC
    @(negedge clk);
    s8 = 1'b1; sm8 = 1'b0; m8 = 8'd9; q8 = 8'd9;
    @(negedge clk);
    s8 = 1'b0;
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_prod", 64'(p8), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("arst_idle", 64'(busy8), 64'd0);
    op8(1'b0, 8'd5, 8'd5, 16'h0019, "post_rst");

    op16(1'b1, 16'h8000, 16'h7FFF, 32'hC0008000, "w16_corner");
    op16(1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_umax");
    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom_range(0, 1));
      rm = 16'($urandom);
      rq = 16'($urandom);
      if (rs) begin
        a = longint'($signed(rm));
        b = longint'($signed(rq));
      end else begin
        a = longint'(rm);
        b = longint'(rq);
      end
      e = 32'(a * b);
      op16(rs, rm, rq, e, $sformatf("rnd%0d_%s", i, rs ? "s" : "u"));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
